car_led_sequencer: RTL and testbench

- Avalon-MM master that sequences the 2-bit car-LED PIO slave. It drives the slave's address, chipselect, write_n and writedata.
- Turns a small mode configuration (off / solid / blink / alternate) and a fault override into timed pattern writes.
- Writes only when the desired pattern differs from the last pattern written.
- Sits between the balance-control status logic and the LED PIO; software no longer toggles LEDs itself.

---
 rtl/car_led_pkg.sv | 26 ++
 rtl/car_led_tick_gen.sv | 36 +++
 rtl/car_led_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_car_led_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/car_led_pkg.sv
// Shared types and constants for the car LED sequencer and its helpers.
// The FSM includes a READ state that is only used when the optional
// readback feature (CAR_LED_SEQUENCER_READBACK_EN) is compiled in.
package car_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_SOLID = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_ALT   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

   // Fault blink half-period in ticks, independent of the configured blink rate
   localparam int FAST_BLINK_TICKS = 4;

   localparam logic [1:0] ALT_PAT_A = 2'b01;
   localparam logic [1:0] ALT_PAT_B = 2'b10;
   localparam logic [1:0] FAULT_PAT = 2'b11;

endpackage

// File: rtl/car_led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV clocks.
// Shared by the car status blocks as their common timebase.
module car_led_tick_gen #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic tick_o
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = (cnt_q == CNT_MAX);

   // Next count: wrap to zero on the tick cycle
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tick_o) begin
         cnt_d = '0;
      end
   end

   // Prescaler register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/car_led_sequencer.sv
// Avalon-MM master that turns the LED mode configuration and the fault
// override into pattern writes to the 2-bit car LED PIO. A write is issued
// only when the desired pattern differs from the last accepted one.
// Optional: define CAR_LED_SEQUENCER_READBACK_EN to read the PIO back after
// every write and flag a sticky readback_err on mismatch.
module car_led_sequencer
   import car_led_pkg::*;
#(
   parameter int CLK_DIV  = 50000,
   parameter int PERIOD_W = 10,
   parameter int PIO_ADDR = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          cfg_mode,
   input  logic [1:0]          cfg_pattern,
   input  logic [PERIOD_W-1:0] cfg_half_period,
   input  logic                fault,
   output logic [1:0]          m_address,
   output logic                m_chipselect,
   output logic                m_write_n,
   output logic [31:0]         m_writedata,
   input  logic                m_waitrequest,
   output logic [1:0]          led_state,
   output logic                busy
`ifdef CAR_LED_SEQUENCER_READBACK_EN
   ,
   output logic                m_read_n,
   input  logic [31:0]         m_readdata,
   output logic                readback_err
`endif
);

   localparam int FAST_W = $clog2(FAST_BLINK_TICKS);
   localparam logic [FAST_W-1:0] FAST_MAX = FAST_W'(FAST_BLINK_TICKS - 1);

   logic                tick;
   logic [PERIOD_W-1:0] eff_hp;
   logic [PERIOD_W-1:0] ph_cnt_q, ph_cnt_d;
   logic                phase_q, phase_d;
   logic                phase_eff;
   logic [FAST_W-1:0]   fast_cnt_q, fast_cnt_d;
   logic                phase_fast_q, phase_fast_d;
   logic [1:0]          mode_q;
   logic                mode_chg;
   logic [1:0]          desired;

   state_e              state_q, state_d;
   logic                cs_q, cs_d;
   logic                wr_n_q, wr_n_d;
   logic                busy_q, busy_d;
   logic [1:0]          wdata_q, wdata_d;
   logic [1:0]          led_q, led_d;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
   logic                rd_n_q, rd_n_d;
   logic                rd_acc_q, rd_acc_d;
   logic                err_q, err_d;
`endif

   car_led_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk_i   (clk),
      .reset_i (reset),
      .tick_o  (tick)
   );

   assign eff_hp   = (cfg_half_period == '0) ? PERIOD_W'(1) : cfg_half_period;
   assign mode_chg = (cfg_mode != mode_q);
   // Mask the phase during the mode-change cycle so a new mode never
   // shows the old mode's phase 1 before the counter is cleared.
   assign phase_eff = phase_q & ~mode_chg;

   // Blink phase counter and fault fast-phase counter, both advanced by tick
   always_comb begin
      ph_cnt_d     = ph_cnt_q;
      phase_d      = phase_q;
      fast_cnt_d   = fast_cnt_q;
      phase_fast_d = phase_fast_q;
      if (mode_chg) begin
         ph_cnt_d = '0;
         phase_d  = 1'b0;
      end else if (tick) begin
         // >= keeps the counter bounded if the half-period shrinks mid-count
         if (ph_cnt_q >= eff_hp - PERIOD_W'(1)) begin
            ph_cnt_d = '0;
            phase_d  = ~phase_q;
         end else begin
            ph_cnt_d = ph_cnt_q + PERIOD_W'(1);
         end
      end
      if (tick) begin
         if (fast_cnt_q == FAST_MAX) begin
            fast_cnt_d   = '0;
            phase_fast_d = ~phase_fast_q;
         end else begin
            fast_cnt_d = fast_cnt_q + FAST_W'(1);
         end
      end
   end

   // Desired LED pattern; fault takes priority over any mode
   always_comb begin
      desired = 2'b00;
      if (fault) begin
         desired = phase_fast_q ? FAULT_PAT : 2'b00;
      end else begin
         case (mode_e'(cfg_mode))
            MODE_OFF:   desired = 2'b00;
            MODE_SOLID: desired = cfg_pattern;
            MODE_BLINK: desired = phase_eff ? cfg_pattern : 2'b00;
            MODE_ALT:   desired = phase_eff ? ALT_PAT_B : ALT_PAT_A;
            default:    desired = 2'b00;
         endcase
      end
   end

   // Bus FSM next state and registered strobe values
   always_comb begin
      state_d = state_q;
      cs_d    = cs_q;
      wr_n_d  = wr_n_q;
      busy_d  = busy_q;
      wdata_d = wdata_q;
      led_d   = led_q;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
      rd_n_d   = rd_n_q;
      rd_acc_d = rd_acc_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (desired != led_q) begin
               wdata_d = desired;
               cs_d    = 1'b1;
               wr_n_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!m_waitrequest) begin
               led_d  = wdata_q;
               wr_n_d = 1'b1;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
               rd_n_d  = 1'b0;
               state_d = READ;
`else
               cs_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
`endif
            end
         end
`ifdef CAR_LED_SEQUENCER_READBACK_EN
         READ: begin
            if (rd_acc_q) begin
               // PIO read data arrives one cycle after the read is accepted
               if (m_readdata[1:0] != led_q) begin
                  err_d = 1'b1;
               end
               rd_acc_d = 1'b0;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else if (!m_waitrequest) begin
               cs_d     = 1'b0;
               rd_n_d   = 1'b1;
               rd_acc_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and bus registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph_cnt_q     <= '0;
         phase_q      <= 1'b0;
         fast_cnt_q   <= '0;
         phase_fast_q <= 1'b0;
         mode_q       <= MODE_OFF;
         state_q      <= IDLE;
         cs_q         <= 1'b0;
         wr_n_q       <= 1'b1;
         busy_q       <= 1'b0;
         wdata_q      <= 2'b00;
         led_q        <= 2'b00;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
         rd_n_q       <= 1'b1;
         rd_acc_q     <= 1'b0;
         err_q        <= 1'b0;
`endif
      end else begin
         ph_cnt_q     <= ph_cnt_d;
         phase_q      <= phase_d;
         fast_cnt_q   <= fast_cnt_d;
         phase_fast_q <= phase_fast_d;
         mode_q       <= cfg_mode;
         state_q      <= state_d;
         cs_q         <= cs_d;
         wr_n_q       <= wr_n_d;
         busy_q       <= busy_d;
         wdata_q      <= wdata_d;
         led_q        <= led_d;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
         rd_n_q       <= rd_n_d;
         rd_acc_q     <= rd_acc_d;
         err_q        <= err_d;
`endif
      end
   end

   assign m_address    = 2'(PIO_ADDR);
   assign m_chipselect = cs_q;
   assign m_write_n    = wr_n_q;
   assign m_writedata  = {30'b0, wdata_q};
   assign led_state    = led_q;
   assign busy         = busy_q;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
   assign m_read_n     = rd_n_q;
   assign readback_err = err_q;
`endif

endmodule

// File: tb/tb_car_led_sequencer.sv
// Directed self-checking bench for car_led_sequencer (CLK_DIV=4).
// With CAR_LED_SEQUENCER_READBACK_EN defined it runs the readback scenario.
module tb_car_led_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  cfg_mode;
   logic [1:0]  cfg_pattern;
   logic [9:0]  cfg_half_period;
   logic        fault;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest;
   logic [1:0]  led_state;
   logic        busy;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
   logic        m_read_n;
   logic [31:0] m_readdata;
   logic        readback_err;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [1:0] wr_dat[$];
   int         wr_cyc[$];

   car_led_sequencer #(
      .CLK_DIV  (4),
      .PERIOD_W (10),
      .PIO_ADDR (0)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cfg_mode        (cfg_mode),
      .cfg_pattern     (cfg_pattern),
      .cfg_half_period (cfg_half_period),
      .fault           (fault),
      .m_address       (m_address),
      .m_chipselect    (m_chipselect),
      .m_write_n       (m_write_n),
      .m_writedata     (m_writedata),
      .m_waitrequest   (m_waitrequest),
      .led_state       (led_state),
      .busy            (busy)
`ifdef CAR_LED_SEQUENCER_READBACK_EN
      ,
      .m_read_n        (m_read_n),
      .m_readdata      (m_readdata),
      .readback_err    (readback_err)
`endif
   );

   always #5 clk = ~clk;

   // Log every accepted write with the index of the accepting edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_chipselect && !m_write_n && !m_waitrequest) begin
         wr_dat.push_back(m_writedata[1:0]);
         wr_cyc.push_back(cyc + 1);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int b;
      int c0;
      int n;
      reset           = 1'b1;
      cfg_mode        = 2'd1;
      cfg_pattern     = 2'b10;
      cfg_half_period = 10'd3;
      fault           = 1'b0;
      m_waitrequest   = 1'b0;
`ifdef CAR_LED_SEQUENCER_READBACK_EN
      m_readdata      = 32'h1;
`endif
      cycles(3);

      // Reset state
      check("rst_cs",    m_chipselect, 1'b0);
      check("rst_wr_n",  m_write_n,    1'b1);
      check("rst_wdata", m_writedata,  32'h0);
      check("rst_led",   led_state,    2'b00);
      check("rst_busy",  busy,         1'b0);
      check("rst_addr",  m_address,    2'b00);

`ifdef CAR_LED_SEQUENCER_READBACK_EN
      check("rst_rd_n",  m_read_n,     1'b1);
      check("rst_err",   readback_err, 1'b0);
      reset = 1'b0;
      cycles(10);
      check("rb_led",    led_state,    2'b10);
      check("rb_err",    readback_err, 1'b1);
      check("rb_busy",   busy,         1'b0);
      cycles(50);
      check("rb_err_sticky", readback_err, 1'b1);
      check("rb_rd_n_idle",  m_read_n,     1'b1);
      reset = 1'b1;
      #1;
      check("rb_err_rst",    readback_err, 1'b0);
      check("rb_led_rst",    led_state,    2'b00);
`else
      // SOLID 2'b10 out of reset: single write, two-cycle latency
      reset = 1'b0;
      c0 = cyc;
      b  = wr_dat.size();
      cycles(1);
      check("solid_cs",    m_chipselect, 1'b1);
      check("solid_wr_n",  m_write_n,    1'b0);
      check("solid_wdata", m_writedata,  32'h2);
      check("solid_busy",  busy,         1'b1);
      cycles(1);
      check("solid_led",   led_state,    2'b10);
      check("solid_cs_off", m_chipselect, 1'b0);
      check("solid_busy_off", busy,      1'b0);
      n = wr_dat.size() - b;
      for (int i = 0; i < n; i++) begin
         check("solid_lat", wr_cyc[b+i] - c0, 2);
         check("solid_val", wr_dat[b+i], 2'b10);
      end
      cycles(1000);
      check("solid_nwr", wr_dat.size() - b, 1);

      // BLINK 2'b11, half-period 3 ticks = 12 clocks
      cfg_mode    = 2'd2;
      cfg_pattern = 2'b11;
      c0 = cyc;
      b  = wr_dat.size();
      cycles(110);
      n = wr_dat.size() - b;
      check("blink_n", n >= 8, 1'b1);
      for (int i = 0; i < n; i++) begin
         check("blink_val", wr_dat[b+i], (i % 2 == 1) ? 2'b11 : 2'b00);
         if (i == 0) check("blink_lat", wr_cyc[b] - c0, 2);
         if (i >= 2) check("blink_per", wr_cyc[b+i] - wr_cyc[b+i-1], 12);
      end

      // ALTERNATE starts in phase 0 with 2'b01
      cfg_mode = 2'd3;
      b = wr_dat.size();
      cycles(40);
      n = wr_dat.size() - b;
      check("alt_n", n >= 3, 1'b1);
      for (int i = 0; i < n; i++) begin
         check("alt_val", wr_dat[b+i], (i % 2 == 1) ? 2'b10 : 2'b01);
      end

      // Fault overrides ALTERNATE with a 4-tick (16-clock) blink of 2'b11
      fault = 1'b1;
      c0 = cyc;
      b  = wr_dat.size();
      cycles(80);
      n = wr_dat.size() - b;
      check("fault_n", n >= 4, 1'b1);
      for (int i = 0; i < n; i++) begin
         if (i == 0) begin
            check("fault_lat", wr_cyc[b] - c0, 2);
            check("fault_val0", (wr_dat[b] == 2'b00) || (wr_dat[b] == 2'b11), 1'b1);
         end else begin
            check("fault_alt", wr_dat[b+i], wr_dat[b+i-1] ^ 2'b11);
         end
         if (i >= 2) check("fault_per", wr_cyc[b+i] - wr_cyc[b+i-1], 16);
      end

      // Fault released: ALTERNATE resumes
      fault = 1'b0;
      c0 = cyc;
      b  = wr_dat.size();
      cycles(30);
      n = wr_dat.size() - b;
      check("resume_n", n >= 1, 1'b1);
      for (int i = 0; i < n && i < 1; i++) begin
         check("resume_lat", wr_cyc[b] - c0, 2);
         check("resume_val", (wr_dat[b] == 2'b01) || (wr_dat[b] == 2'b10), 1'b1);
      end

      // Waitrequest stall with desired changing mid-write
      cfg_mode    = 2'd1;
      cfg_pattern = 2'b01;
      cycles(6);
      check("ws_pre_led", led_state, 2'b01);
      m_waitrequest = 1'b1;
      cfg_pattern   = 2'b10;
      cycles(1);
      cfg_pattern   = 2'b11;
      for (int i = 0; i < 5; i++) begin
         check("ws_cs",    m_chipselect, 1'b1);
         check("ws_wr_n",  m_write_n,    1'b0);
         check("ws_wdata", m_writedata,  32'h2);
         check("ws_led",   led_state,    2'b01);
         if (i < 4) cycles(1);
      end
      m_waitrequest = 1'b0;
      cycles(1);
      check("ws_led_1st", led_state,    2'b10);
      check("ws_idle_cs", m_chipselect, 1'b0);
      cycles(1);
      check("ws_cs_2nd",    m_chipselect, 1'b1);
      check("ws_wdata_2nd", m_writedata,  32'h3);
      cycles(1);
      check("ws_led_2nd",   led_state,    2'b11);

      // Asynchronous reset during a stalled write
      m_waitrequest = 1'b1;
      cfg_pattern   = 2'b00;
      cycles(1);
      check("ar_cs_pre", m_chipselect, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_cs",    m_chipselect, 1'b0);
      check("ar_wr_n",  m_write_n,    1'b1);
      check("ar_led",   led_state,    2'b00);
      check("ar_busy",  busy,         1'b0);
      check("ar_wdata", m_writedata,  32'h0);
      cycles(2);
      cfg_mode      = 2'd0;
      m_waitrequest = 1'b0;
      reset         = 1'b0;
      b = wr_dat.size();
      cycles(20);
      check("ar_nwr",     wr_dat.size() - b, 0);
      check("ar_led_off", led_state,    2'b00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
